fft_bitrev_buffer: RTL and testbench

FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

---
 rtl/fft_bitrev_buffer.sv | 136 +++++++++++++
 tb/tb_fft_bitrev_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong bit-reversal buffer: natural-order samples in, radix-2 butterfly operand pairs out.
// Optional framing checks and the frame_err port are enabled by defining FFT_BITREV_ERR_EN.
package fft_bitrev_pkg;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;
endpackage

module fft_bitrev_buffer
    import fft_bitrev_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  complex_t in_data,
    input  logic     in_last,
    output logic     out_valid,
    input  logic     out_ready,
    output complex_t out_a,
    output complex_t out_b,
    output logic     out_first
`ifdef FFT_BITREV_ERR_EN
    ,
    output logic     frame_err
`endif
);

    localparam int unsigned LGN = $clog2(N);
    localparam int unsigned NP  = N / 2;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t      state_q [2];
    bank_state_t      state_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LGN-1:0]   wr_idx_q, wr_idx_d;
    logic [LGN-2:0]   k_q, k_d;
    complex_t         mem [2][N];

    logic             in_xfer, out_xfer, last_idx, early_last;
    logic [LGN-1:0]   idx_a, idx_b;

    function automatic logic [LGN-1:0] bitrev(input logic [LGN-1:0] x);
        logic [LGN-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < LGN; b++) r[b] = x[LGN-1-b];
        return r;
    endfunction

    assign in_ready  = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
    assign out_valid = (state_q[rd_bank_q] == FULL)  || (state_q[rd_bank_q] == DRAINING);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_idx  = (wr_idx_q == LGN'(N - 1));

`ifdef FFT_BITREV_ERR_EN
    logic err_d;
    assign early_last = in_last && !last_idx;
    assign err_d      = in_xfer && (in_last != last_idx);

    always_ff @(posedge clk) begin
        if (reset) frame_err <= 1'b0;
        else       frame_err <= err_d;
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign early_last     = 1'b0;
`endif

    // The write bank is always EMPTY/FILLING and the read bank FULL/DRAINING whenever
    // each transfers, so both updates never touch the same bank in one cycle.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        k_d       = k_q;
        if (in_xfer) begin
            if (last_idx) begin
                state_d[wr_bank_q] = FULL;
                wr_idx_d           = '0;
                wr_bank_d          = ~wr_bank_q;
            end else if (early_last) begin
                state_d[wr_bank_q] = FILLING;
                wr_idx_d           = '0;
            end else begin
                state_d[wr_bank_q] = FILLING;
                wr_idx_d           = wr_idx_q + 1'b1;
            end
        end
        if (out_xfer) begin
            if (k_q == (LGN-1)'(NP - 1)) begin
                state_d[rd_bank_q] = EMPTY;
                k_d                = '0;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                state_d[rd_bank_q] = DRAINING;
                k_d                = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            k_q        <= k_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && in_xfer) mem[wr_bank_q][wr_idx_q] <= in_data;
    end

    assign idx_a     = bitrev({k_q, 1'b0});
    assign idx_b     = bitrev({k_q, 1'b1});
    assign out_a     = out_valid ? mem[rd_bank_q][idx_a] : '0;
    assign out_b     = out_valid ? mem[rd_bank_q][idx_b] : '0;
    assign out_first = out_valid && (k_q == '0);

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Randomized self-checking bench for fft_bitrev_buffer against a frame-queue reference model.
// Framing-error scenarios run when FFT_BITREV_ERR_EN is defined.
module tb_fft_bitrev_buffer;
    import fft_bitrev_pkg::*;

    localparam int N   = 8;
    localparam int NP  = N / 2;
    localparam int LGN = 3;

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    logic     in_valid = 1'b0;
    logic     in_ready;
    complex_t in_data = '0;
    logic     in_last = 1'b0;
    logic     out_valid;
    logic     out_ready = 1'b0;
    complex_t out_a, out_b;
    logic     out_first;
    logic     err_bit;

    always #5 clk = ~clk;

`ifdef FFT_BITREV_ERR_EN
    logic frame_err;
    assign err_bit = frame_err;
`else
    assign err_bit = 1'b0;
`endif

    fft_bitrev_buffer #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_first(out_first)
`ifdef FFT_BITREV_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    // Reference model: completed frames become a queue of expected pairs.
    complex_t exp_a[$];
    complex_t exp_b[$];
    complex_t cur[N];
    int       cur_cnt = 0;
    logic     exp_err = 1'b0;
    int       checks = 0;
    int       passed = 0;

    function automatic int rev(input int v);
        int x = v;
        int r = 0;
        repeat (LGN) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic int frames_held();
        return (exp_a.size() + NP - 1) / NP;
    endfunction

    function automatic logic model_ready();
        return frames_held() < 2;
    endfunction

    function automatic logic [67:0] exp_vec();
        logic     v = exp_a.size() > 0;
        complex_t a = v ? exp_a[0] : '0;
        complex_t b = v ? exp_b[0] : '0;
        return {model_ready(), v, v && (exp_a.size() % NP == 0), a, b, exp_err};
    endfunction

    function automatic logic [67:0] obs_vec();
        return {in_ready, out_valid, out_first, out_a, out_b, err_bit};
    endfunction

    task automatic tick();
        logic ix, ox;
        int   a;
        @(posedge clk);
        if (reset) begin
            exp_a.delete();
            exp_b.delete();
            cur_cnt = 0;
            exp_err = 1'b0;
        end else begin
            ix = in_valid && model_ready();
            ox = out_ready && (exp_a.size() > 0);
            if (ox) begin
                void'(exp_a.pop_front());
                void'(exp_b.pop_front());
            end
            exp_err = 1'b0;
            if (ix) begin
                cur[cur_cnt] = in_data;
`ifdef FFT_BITREV_ERR_EN
                exp_err = (in_last != (cur_cnt == N - 1));
                if (in_last && cur_cnt != N - 1) cur_cnt = -1;
`endif
                if (cur_cnt == N - 1) begin
                    for (int k = 0; k < NP; k++) begin
                        a = rev(2 * k);
                        exp_a.push_back(cur[a]);
                        exp_b.push_back(cur[a + NP]);
                    end
                    cur_cnt = 0;
                end else begin
                    cur_cnt++;
                end
            end
        end
        #1;
    endtask

    function automatic complex_t rnd_sample();
        complex_t s;
        s.re = 16'($urandom);
        s.im = 16'($urandom);
        return s;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = rnd_sample(); out_ready = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec() !== 68'h8_0000_0000_0000_0000)
            $display("FAIL reset got=%h exp=%h", obs_vec(), 68'h8_0000_0000_0000_0000);
        else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int got[$];
        int want[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < N);
            in_data  = '{re: 16'(c), im: 16'sd0};
            in_last  = (cur_cnt == N - 1);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL single_frame c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else passed++;
            if (out_valid) begin
                got.push_back(int'(out_a.re));
                got.push_back(int'(out_b.re));
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got.size() || got[i] != want[i])
                $display("FAIL pair_order i=%0d got=%0d exp=%0d", i, (i < got.size()) ? got[i] : -1, want[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int pairs = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 36; c++) begin
            in_valid = (c < 3 * N);
            in_data  = rnd_sample();
            in_last  = (cur_cnt == N - 1);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else passed++;
            if (out_valid) pairs++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (pairs != 3 * NP) $display("FAIL b2b_pairs got=%0d exp=%0d", pairs, 3 * NP);
        else passed++;
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 40; c++) begin
            in_valid  = (c < 22);
            out_ready = (c >= 26);
            in_data   = rnd_sample();
            in_last   = (cur_cnt == N - 1);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL backpressure c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else passed++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = (c < 380) && ($urandom_range(3) != 0);
            out_ready = (c >= 380) || ($urandom_range(2) != 0);
            in_data   = rnd_sample();
            in_last   = (cur_cnt == N - 1);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else passed++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            reset    = (c == 5);
            in_valid = (c != 5) && (c < 14);
            in_data  = rnd_sample();
            in_last  = (cur_cnt == N - 1);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else passed++;
            tick();
        end
        reset = 1'b0; in_valid = 1'b0;
    endtask

`ifdef FFT_BITREV_ERR_EN
    task automatic test_early_last();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 12);
            in_data  = rnd_sample();
            in_last  = (c == 3) || (c >= 4 && cur_cnt == N - 1);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL early_last c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else passed++;
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_missing_last();
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < N);
            in_data  = rnd_sample();
            in_last  = 1'b0;
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL missing_last c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            else passed++;
            tick();
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
`ifdef FFT_BITREV_ERR_EN
        test_early_last();
        test_missing_last();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
